// File: rtl/aead_poly_sequencer_if.sv
// Block-stream and multiply/reduce engine bus for the Poly1305 sequencer.
// slave is the sequencer's view; master is the source/engine side.
interface aead_poly_sequencer_if;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         blk_ready;
    logic         eng_start;
    logic [129:0] eng_a;
    logic [127:0] eng_r;
    logic         eng_done;
    logic [129:0] eng_result;

    modport master (
        output blk_valid, blk_data, eng_done, eng_result,
        input  blk_ready, eng_start, eng_a, eng_r
    );

    modport slave (
        input  blk_valid, blk_data, eng_done, eng_result,
        output blk_ready, eng_start, eng_a, eng_r
    );
endinterface

// File: rtl/aead_poly_sequencer.sv
// ChaCha20-Poly1305 MAC sequencer: pads AAD/CT blocks, appends the length block,
// drives a shared 130x128 multiply/reduce engine and forms the final tag.
module aead_poly_sequencer #(
    parameter int LEN_W = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [127:0]     r_key,
    input  logic [127:0]     s_key,
    input  logic [LEN_W-1:0] aad_len,
    input  logic [LEN_W-1:0] ct_len,
    aead_poly_sequencer_if.slave bus,
    output logic             busy,
    output logic [127:0]     tag,
    output logic             tag_valid
);
    typedef enum logic [2:0] {IDLE, WAIT_BLK, ENG_REQ, ENG_WAIT, LEN_BLK, FINAL} state_t;
    typedef enum logic [1:0] {PH_AAD, PH_CT, PH_LEN} phase_t;

    localparam logic [127:0] R_CLAMP = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
    localparam logic [129:0] P1305   = 130'h3_ffffffff_ffffffff_ffffffff_fffffffb;

    state_t             state_reg;
    phase_t             phase_reg;
    logic [129:0]       acc_reg;
    logic [127:0]       r_reg;
    logic [127:0]       s_reg;
    logic [LEN_W-1:0]   aad_len_reg;
    logic [LEN_W-1:0]   ct_len_reg;
    logic [LEN_W-1:0]   aad_rem_reg;
    logic [LEN_W-1:0]   ct_rem_reg;
    logic               blk_ready_reg;
    logic               eng_start_reg;
    logic [129:0]       eng_a_reg;
    logic               busy_reg;
    logic [127:0]       tag_reg;
    logic               tag_valid_reg;

    logic [LEN_W-1:0]   rem_sel;
    logic [4:0]         take;
    logic [127:0]       masked;
    logic [127:0]       len_word;
    logic [127:0]       fold_src;
    logic [130:0]       fold_sum;
    logic [129:0]       fold_a;
    logic [127:0]       acc_red;
    logic               handshake;

    assign rem_sel   = (phase_reg == PH_AAD) ? aad_rem_reg : ct_rem_reg;
    assign take      = (rem_sel >= LEN_W'(16)) ? 5'd16 : rem_sel[4:0];
    assign handshake = bus.blk_valid && blk_ready_reg;

    // Bytes at or beyond the remaining count are zero-padded.
    for (genvar gi = 0; gi < 16; gi++) begin : g_mask
        assign masked[8*gi +: 8] = (5'(gi) < take) ? bus.blk_data[8*gi +: 8] : 8'h00;
    end

    assign len_word = {64'(ct_len_reg), 64'(aad_len_reg)};
    assign fold_src = (state_reg == LEN_BLK) ? len_word : masked;
    assign fold_sum = {1'b0, acc_reg} + {3'b001, fold_src};
    // A carry out of bit 130 is worth 2^130 == 5 (mod p).
    assign fold_a   = fold_sum[130] ? (fold_sum[129:0] + 130'd5) : fold_sum[129:0];
    assign acc_red  = (acc_reg >= P1305) ? (acc_reg[127:0] - P1305[127:0]) : acc_reg[127:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            phase_reg     <= PH_AAD;
            acc_reg       <= '0;
            r_reg         <= '0;
            s_reg         <= '0;
            aad_len_reg   <= '0;
            ct_len_reg    <= '0;
            aad_rem_reg   <= '0;
            ct_rem_reg    <= '0;
            blk_ready_reg <= 1'b0;
            eng_start_reg <= 1'b0;
            eng_a_reg     <= '0;
            busy_reg      <= 1'b0;
            tag_reg       <= '0;
            tag_valid_reg <= 1'b0;
        end else begin
            eng_start_reg <= 1'b0;
            tag_valid_reg <= 1'b0;
            if (abort) begin
                state_reg     <= IDLE;
                blk_ready_reg <= 1'b0;
                busy_reg      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            r_reg       <= r_key & R_CLAMP;
                            s_reg       <= s_key;
                            aad_len_reg <= aad_len;
                            ct_len_reg  <= ct_len;
                            aad_rem_reg <= aad_len;
                            ct_rem_reg  <= ct_len;
                            acc_reg     <= '0;
                            busy_reg    <= 1'b1;
                            phase_reg   <= (aad_len == '0) ? PH_CT : PH_AAD;
                            if (aad_len == '0 && ct_len == '0) begin
                                state_reg <= LEN_BLK;
                            end else begin
                                state_reg     <= WAIT_BLK;
                                blk_ready_reg <= 1'b1;
                            end
                        end
                    end
                    WAIT_BLK: begin
                        if (handshake) begin
                            eng_a_reg <= fold_a;
                            if (phase_reg == PH_AAD) aad_rem_reg <= aad_rem_reg - LEN_W'(take);
                            else                     ct_rem_reg  <= ct_rem_reg - LEN_W'(take);
                            blk_ready_reg <= 1'b0;
                            eng_start_reg <= 1'b1;
                            state_reg     <= ENG_REQ;
                        end
                    end
                    LEN_BLK: begin
                        eng_a_reg     <= fold_a;
                        phase_reg     <= PH_LEN;
                        eng_start_reg <= 1'b1;
                        state_reg     <= ENG_REQ;
                    end
                    ENG_REQ: state_reg <= ENG_WAIT;
                    ENG_WAIT: begin
                        if (bus.eng_done) begin
                            acc_reg <= bus.eng_result;
                            if (phase_reg == PH_LEN) begin
                                state_reg <= FINAL;
                            end else if (phase_reg == PH_AAD && aad_rem_reg == '0) begin
                                phase_reg <= PH_CT;
                                if (ct_len_reg != '0) begin
                                    state_reg     <= WAIT_BLK;
                                    blk_ready_reg <= 1'b1;
                                end else begin
                                    state_reg <= LEN_BLK;
                                end
                            end else if (phase_reg == PH_CT && ct_rem_reg == '0) begin
                                state_reg <= LEN_BLK;
                            end else begin
                                state_reg     <= WAIT_BLK;
                                blk_ready_reg <= 1'b1;
                            end
                        end
                    end
                    FINAL: begin
                        tag_reg       <= acc_red + s_reg;
                        tag_valid_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.blk_ready = blk_ready_reg;
    assign bus.eng_start = eng_start_reg;
    assign bus.eng_a     = eng_a_reg;
    assign bus.eng_r     = r_reg;
    assign busy          = busy_reg;
    assign tag           = tag_reg;
    assign tag_valid     = tag_valid_reg;
endmodule

// File: tb/tb_aead_poly_sequencer.sv
// Scoreboard bench for aead_poly_sequencer with a behavioural a*r mod p engine
// and an independent Poly1305 reference model.
module tb_aead_poly_sequencer;
    localparam logic [129:0] P130      = 130'h3_ffffffff_ffffffff_ffffffff_fffffffb;
    localparam logic [257:0] P258      = 258'(P130);
    localparam logic [127:0] CLAMP     = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
    localparam logic [129:0] FORCE_VAL = 130'h3_ffffffff_ffffffff_ffffffff_fffffffd;

    logic         clk = 1'b0;
    logic         reset_n, start, abort;
    logic [127:0] r_key, s_key;
    logic [63:0]  aad_len, ct_len;
    logic         busy, tag_valid;
    logic [127:0] tag;

    aead_poly_sequencer_if bus();

    aead_poly_sequencer #(.LEN_W(64)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .r_key(r_key), .s_key(s_key), .aad_len(aad_len), .ct_len(ct_len),
        .bus(bus), .busy(busy), .tag(tag), .tag_valid(tag_valid)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           failures = 0;
    logic [129:0] eng_exp_q[$];
    logic [127:0] tag_exp_q[$];
    int           calls_in_run = 0;
    int           tag_count = 0;
    int           fixed_lat = 3;
    bit           rnd_mode = 0;
    bit           force_final = 0;
    int           force_idx = 0;
    bit           eng_busy = 0;
    logic [127:0] exp_r = '0;
    logic [127:0] last_tag = '0;
    logic [127:0] msg_aad[4];
    logic [127:0] msg_ct[4];

    task automatic check(input string name, input logic [131:0] got, input logic [131:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [129:0] modp(input logic [257:0] x);
        logic [257:0] t;
        t = x % P258;
        return t[129:0];
    endfunction

    function automatic logic [129:0] mulmod(input logic [129:0] a, input logic [127:0] r);
        return modp(258'(a) * 258'(r));
    endfunction

    function automatic logic [129:0] addmod(input logic [129:0] a, input logic [129:0] b);
        return modp(258'(a) + 258'(b));
    endfunction

    function automatic logic [127:0] mask_blk(input logic [127:0] d, input int n);
        logic [127:0] m;
        m = d;
        for (int b = 0; b < 16; b++) if (b >= n) m[8*b +: 8] = 8'h00;
        return m;
    endfunction

    // Behavioural engine: answers each eng_start after a fixed or random latency.
    initial begin
        logic [129:0] a_cap, res, ea;
        logic [127:0] r_cap;
        int lat;
        bus.eng_done   = 1'b0;
        bus.eng_result = '0;
        forever begin
            @(negedge clk);
            if (bus.eng_start === 1'b1) begin
                eng_busy = 1;
                a_cap = bus.eng_a;
                r_cap = bus.eng_r;
                ea = (eng_exp_q.size() > 0) ? eng_exp_q.pop_front() : {130{1'b1}};
                check("eng_a_modp", 132'(modp(258'(a_cap))), 132'(ea));
                check("eng_r", 132'(r_cap), 132'(exp_r));
                $display("ENG call=%0d eng_a=%h", calls_in_run, a_cap);
                lat = rnd_mode ? int'($urandom_range(1, 40)) : fixed_lat;
                repeat (lat) begin
                    @(negedge clk);
                    check("blk_ready_in_eng", 132'(bus.blk_ready), 132'(0));
                    check("eng_a_stable", 132'(bus.eng_a), 132'(a_cap));
                end
                res = (force_final && calls_in_run == force_idx) ? FORCE_VAL : mulmod(a_cap, r_cap);
                bus.eng_result = res;
                bus.eng_done   = 1'b1;
                calls_in_run++;
                @(negedge clk);
                bus.eng_done = 1'b0;
                eng_busy = 0;
            end
        end
    end

    // Tag monitor: pops the expected tag on every tag_valid pulse.
    initial begin
        logic [127:0] et;
        forever begin
            @(negedge clk);
            if (tag_valid === 1'b1) begin
                check("tag_pending", 132'(tag_exp_q.size() != 0), 132'(1));
                if (tag_exp_q.size() != 0) begin
                    et = tag_exp_q.pop_front();
                    check("tag", 132'(tag), 132'(et));
                end
                check("busy_at_tag", 132'(busy), 132'(0));
                last_tag = tag;
                tag_count++;
                $display("TAG n=%0d tag=%h", tag_count, tag);
            end
        end
    end

    task automatic send_block(input logic [127:0] d);
        int  g = 0;
        bit  done = 0;
        while (!done) begin
            @(negedge clk);
            if (rnd_mode && $urandom_range(0, 2) == 0) begin
                bus.blk_valid = 1'b0;
                bus.blk_data  = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                bus.blk_valid = 1'b1;
                bus.blk_data  = d;
            end
            if (bus.blk_valid && bus.blk_ready) begin
                @(posedge clk);
                #1;
                bus.blk_valid = 1'b0;
                done = 1;
            end
            g++;
            if (!done && g > 3000) begin
                check("blk_handshake_timeout", 132'(bus.blk_ready), 132'(1));
                bus.blk_valid = 1'b0;
                done = 1;
            end
        end
    endtask

    task automatic run_msg(input logic [127:0] rk, input logic [127:0] sk, input int alen,
                           input int clen, input bit rnd, input bit frc, input int exp_calls);
        logic [129:0] acc, a, blk;
        logic [127:0] rc, exp_tag;
        int n, ncalls, tc0, guard;
        rc = rk & CLAMP;
        acc = '0;
        ncalls = 0;
        for (int i = 0; i < (alen + 15) / 16; i++) begin
            n = (alen - 16 * i > 16) ? 16 : alen - 16 * i;
            blk = {2'b01, mask_blk(msg_aad[i], n)};
            a = addmod(acc, blk);
            eng_exp_q.push_back(a);
            acc = mulmod(a, rc);
            ncalls++;
        end
        for (int i = 0; i < (clen + 15) / 16; i++) begin
            n = (clen - 16 * i > 16) ? 16 : clen - 16 * i;
            blk = {2'b01, mask_blk(msg_ct[i], n)};
            a = addmod(acc, blk);
            eng_exp_q.push_back(a);
            acc = mulmod(a, rc);
            ncalls++;
        end
        blk = {2'b01, 64'(clen), 64'(alen)};
        a = addmod(acc, blk);
        eng_exp_q.push_back(a);
        acc = frc ? FORCE_VAL : mulmod(a, rc);
        ncalls++;
        if (acc >= P130) acc = acc - P130;
        exp_tag = acc[127:0] + sk;
        tag_exp_q.push_back(exp_tag);

        exp_r = rc;
        rnd_mode = rnd;
        force_final = frc;
        force_idx = ncalls - 1;
        calls_in_run = 0;
        tc0 = tag_count;

        @(negedge clk);
        r_key = rk; s_key = sk; aad_len = 64'(alen); ct_len = 64'(clen); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 132'(busy), 132'(1));
        for (int i = 0; i < (alen + 15) / 16; i++) send_block(msg_aad[i]);
        for (int i = 0; i < (clen + 15) / 16; i++) send_block(msg_ct[i]);
        guard = 0;
        while (tag_count == tc0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("tag_seen", 132'(tag_count - tc0), 132'(1));
        check("engine_calls", 132'(calls_in_run), 132'(exp_calls));
        repeat (3) @(negedge clk);
        check("busy_idle", 132'(busy), 132'(0));
        check("tag_held", 132'(tag), 132'(exp_tag));
        check("tag_valid_pulse", 132'(tag_valid), 132'(0));
        force_final = 0;
        rnd_mode = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] tag_fixed;
        int tc0, guard;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        r_key = '0; s_key = '0; aad_len = '0; ct_len = '0;
        bus.blk_valid = 1'b0; bus.blk_data = '0;
        for (int i = 0; i < 4; i++) begin msg_aad[i] = '0; msg_ct[i] = '0; end
        #12;
        check("rst_blk_ready", 132'(bus.blk_ready), 132'(0));
        check("rst_eng_start", 132'(bus.eng_start), 132'(0));
        check("rst_eng_a", 132'(bus.eng_a), 132'(0));
        check("rst_eng_r", 132'(bus.eng_r), 132'(0));
        check("rst_busy", 132'(busy), 132'(0));
        check("rst_tag", 132'(tag), 132'(0));
        check("rst_tag_valid", 132'(tag_valid), 132'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Empty message: only the length block, tag equals s.
        run_msg(128'h1, 128'h0123456789abcdef0123456789abcdef, 0, 0, 0, 0, 1);
        check("empty_tag_is_s", 132'(last_tag), 132'(128'h0123456789abcdef0123456789abcdef));

        // Three AAD bytes of 0xFF, no ciphertext.
        msg_aad[0] = {128{1'b1}};
        run_msg(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 128'h55aa55aa00ff00ff1234567890abcdef, 3, 0, 0, 0, 2);

        // RFC 8439 key material, truncated AAD/CT.
        msg_aad[0] = 128'h00000000_c7c6c5c4_c3c2c1c0_53525150;
        msg_ct[0]  = 128'hc27eef53bcaf867bdb608e64348d1ad3;
        msg_ct[1]  = 128'hd662ee36a7b5e2a9fe086e2951edada4;
        run_msg(128'h8455e9a4557ab609af47b42d252bac7b, 128'hff53d53e7875932aebd9751073d6e10a,
                16, 20, 0, 0, 4);
        tag_fixed = last_tag;

        // Same message with random engine latency and bursty blk_valid.
        run_msg(128'h8455e9a4557ab609af47b42d252bac7b, 128'hff53d53e7875932aebd9751073d6e10a,
                16, 20, 1, 0, 4);
        check("tag_vs_fixed_latency", 132'(last_tag), 132'(tag_fixed));

        // Abort during the first engine call, then a late eng_done.
        begin
            logic [129:0] a0;
            a0 = addmod('0, {2'b01, msg_aad[0]});
            eng_exp_q.push_back(a0);
            exp_r = 128'h8455e9a4557ab609af47b42d252bac7b & CLAMP;
            fixed_lat = 20;
            calls_in_run = 0;
            tc0 = tag_count;
            @(negedge clk);
            r_key = 128'h8455e9a4557ab609af47b42d252bac7b; s_key = 128'h1;
            aad_len = 64'd16; ct_len = 64'd16; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            send_block(msg_aad[0]);
            guard = 0;
            while (!eng_busy && guard < 100) begin @(negedge clk); guard++; end
            check("abort_engine_started", 132'(eng_busy), 132'(1));
            repeat (3) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("abort_busy", 132'(busy), 132'(0));
            check("abort_blk_ready", 132'(bus.blk_ready), 132'(0));
            guard = 0;
            while (eng_busy && guard < 100) begin @(negedge clk); guard++; end
            repeat (3) @(negedge clk);
            check("abort_no_tag", 132'(tag_count - tc0), 132'(0));
            check("abort_tag_unchanged", 132'(tag), 132'(tag_fixed));
            // start coincident with abort must be dropped.
            start = 1'b1; abort = 1'b1;
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            check("start_abort_busy", 132'(busy), 132'(0));
            fixed_lat = 3;
        end
        run_msg(128'h8455e9a4557ab609af47b42d252bac7b, 128'hff53d53e7875932aebd9751073d6e10a,
                16, 20, 0, 0, 4);
        check("after_abort_tag", 132'(last_tag), 132'(tag_fixed));

        // Engine returns 2^130-3 on the length block; final reduction gives 2.
        run_msg(128'h1, 128'h0, 0, 0, 0, 1, 1);
        check("final_reduce_tag", 132'(last_tag), 132'(2));

        check("eng_queue_drained", 132'(eng_exp_q.size()), 132'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aead_poly_sequencer.md
Name: aead_poly_sequencer

Overview:
Sequences the ChaCha20-Poly1305 AEAD MAC computation over a shared 130x128 multiply/reduce engine. Accepts a stream of 128-bit AAD blocks followed by ciphertext blocks and zero-pads partial blocks by byte count. Appends the RFC 8439 length block, drives the engine one block at a time and produces the final 128-bit tag. Sits between the ChaCha20 keystream/ciphertext path and the multiplier+reducer pair, replacing ad-hoc sequencing inside the AEAD core.

Parameters:
LEN_W, 64, width of the aad_len / ct_len byte counts

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches keys and lengths; ignored unless idle
abort  in  1  synchronous abort; returns to IDLE from any state
r_key  in  128  Poly1305 r; clamped internally
s_key  in  128  Poly1305 s
aad_len  in  LEN_W  AAD length in bytes
ct_len  in  LEN_W  ciphertext length in bytes
blk_valid  in  1  input block valid
blk_data  in  128  block data, little-endian (byte 0 = [7:0])
blk_ready  out  1  block accepted when blk_valid && blk_ready
eng_start  out  1  one-cycle engine request pulse
eng_a  out  130  accumulator+block operand, stable from eng_start until eng_done
eng_r  out  128  clamped r, stable while busy
eng_done  in  1  one-cycle engine completion pulse
eng_result  in  130  (eng_a*eng_r) partially reduced, < 2^130, valid with eng_done
busy  out  1  high from the cycle after an accepted start until tag_valid
tag  out  128  final tag, held until the next start
tag_valid  out  1  one-cycle pulse when tag is updated

Behaviour:
- Reset (async): state IDLE, acc=0, all counters 0; blk_ready=0, eng_start=0, eng_a=0, eng_r=0, busy=0, tag=0, tag_valid=0.
- Clamp: r_c = r_key & 0x0ffffffc0ffffffc0ffffffc0fffffff, registered at start.
- States: IDLE, WAIT_BLK, ENG_REQ, ENG_WAIT, LEN_BLK, FINAL.
- IDLE: on start, latch r_c, s_key, aad_rem=aad_len, ct_rem=ct_len; clear acc; set phase=AAD, or CT if aad_len==0. If both lengths are 0, go to LEN_BLK; otherwise go to WAIT_BLK.
- WAIT_BLK: blk_ready=1. On handshake, mask bytes with index >= min(rem,16) to 0. Form blk = {1'b1, masked} (the 2^128 bit is always set; AEAD pads every segment to 16 bytes). Then rem -= min(rem,16) and go to ENG_REQ.
- Operand fold: sum = acc + blk (131 bits). If sum[130] is set, eng_a = sum[129:0] + 5; else eng_a = sum[129:0].
- ENG_REQ: eng_start=1 for exactly one cycle, then ENG_WAIT.
- ENG_WAIT: on eng_done, acc <= eng_result, then route:
  - If the segment is not exhausted, go to WAIT_BLK.
  - If the AAD segment is exhausted, switch phase to CT. Go to WAIT_BLK if ct_len>0, else LEN_BLK.
  - If the CT segment is exhausted, go to LEN_BLK.
  - If the length block was just processed, go to FINAL.
- eng_done outside ENG_WAIT is ignored.
- LEN_BLK: blk = {1'b1, ct_len, aad_len} (ct_len in bits [127:64]). Fold as above, then ENG_REQ; no input handshake.
- FINAL (1 cycle): a = acc; if a >= p (p=2^130-5) then a -= p. tag <= (a[127:0] + s) mod 2^128; tag_valid=1; busy=0; go to IDLE.
- Latency per block: 1 cycle after handshake to eng_start, plus engine latency, plus 1 cycle.
- blk_ready is low in every state except WAIT_BLK; blocks are never accepted during engine operation.
- abort: highest priority; next state IDLE, eng_start=0, blk_ready=0, busy=0, tag unchanged, no tag_valid. An eng_done arriving after abort is ignored.
- start while busy: ignored. start coincident with abort: abort wins.
- Lengths are byte-exact; a rem of exactly 16 counts as a full block with no masking.

Test Plan:
- aad_len=0, ct_len=0, r_key=1, s_key=0x0123..ef, behavioural engine (a*r mod p) -> single engine call with eng_a=2^128 + 0 (length block all zero), tag=s_key, tag_valid one pulse, busy low after.
- aad_len=3, ct_len=0, blk_data=all 0xFF -> first eng_a = 2^128 + 0xFFFFFF. Length block low 64 bits = 3.
- aad_len=16, ct_len=20, r/s/data from the RFC 8439 section 2.8.2 vector truncated -> exactly 4 engine calls (1 AAD, 2 CT, 1 length). Second CT block masked to 4 bytes. Tag matches a reference model.
- Engine latency randomised 1..40 cycles with blk_valid toggled randomly -> blk_ready never high in ENG_WAIT; eng_a stable from eng_start to eng_done; tag unchanged vs fixed-latency run.
- abort asserted in ENG_WAIT, then a late eng_done, then a new start -> acc restarts from 0; late done ignored; second tag correct; no tag_valid for the aborted run.
- FINAL reduction: force the engine model to return acc = 2^130-3 on the length block, s=0 -> tag = 2 (since 2^130-3 - p = 2).
